// File: rtl/quiz_buzzer_core.sv
// quiz_buzzer_core: 2..4 player buzzer arbitration, judging, scoring,
// keypad point entry, multiplexed score display and timed beeper.
// Ports: clk, rst (async low), reload/beginNew (sync low), Answer, Yes, No,
//   select1/2, row in; col, DIG, seg_out, getter, led, alarm out.
module quiz_buzzer_core #(
  parameter int SEC_DIV   = 50_000_000,
  parameter int TONE_DIV  = 50_000,
  parameter int SCAN_DIV  = 50_000,
  parameter int ALARM_SEC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reload,
  input  logic       beginNew,
  input  logic [3:0] Answer,
  input  logic       Yes,
  input  logic       No,
  input  logic       select1,
  input  logic       select2,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [7:0] DIG,
  output logic [7:0] seg_out,
  output logic       getter,
  output logic [3:0] led,
  output logic       alarm
);

  localparam int SW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int AW = $clog2(ALARM_SEC + 1);

  logic [3:0]    en;
  logic [3:0]    ans;
  logic          claim;
  logic          yes_q;
  logic          no_q;
  logic          yes_e;
  logic          no_e;
  logic          graded;
  logic          win_open;
  logic          tick;
  logic [SW-1:0] sec_cnt;
  logic [TW-1:0] tone_cnt;
  logic [AW-1:0] tick_cnt;
  logic [1:0]    win_idx;
  logic [3:0]    pts;
  logic [6:0]    score [4];
  logic [6:0]    cur;
  logic [7:0]    sum;
  logic [6:0]    sc_add;
  logic [6:0]    sc_sub;

  always_comb begin
    unique case ({select2, select1})
      2'b01:   en = 4'b0011;
      2'b10:   en = 4'b0111;
      default: en = 4'b1111;
    endcase
  end

  // Disabled players' buzzers are treated as not pressed.
  assign ans   = Answer & en;
  assign claim = (ans != 4'b0000) && ((ans & (ans - 4'd1)) == 4'b0000);

  assign yes_e = Yes & ~yes_q;
  assign no_e  = No & ~no_q;
  assign tick  = getter && (sec_cnt == SW'(SEC_DIV - 1));

  always_comb begin
    win_idx = 2'd0;
    unique case (1'b1)
      led[1]:  win_idx = 2'd1;
      led[2]:  win_idx = 2'd2;
      led[3]:  win_idx = 2'd3;
      default: win_idx = 2'd0;
    endcase
  end

  assign cur    = score[win_idx];
  assign sum    = {1'b0, cur} + {4'd0, pts};
  assign sc_add = (sum > 8'd99) ? 7'd99 : sum[6:0];
  assign sc_sub = (cur > {3'd0, pts}) ? cur - {3'd0, pts} : 7'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      getter   <= 1'b0;
      led      <= 4'b0000;
      alarm    <= 1'b0;
      win_open <= 1'b0;
      graded   <= 1'b0;
      sec_cnt  <= '0;
      tone_cnt <= '0;
      tick_cnt <= '0;
      yes_q    <= 1'b0;
      no_q     <= 1'b0;
      for (int i = 0; i < 4; i++) score[i] <= 7'd0;
    end else begin
      yes_q <= Yes;
      no_q  <= No;
      if (!beginNew || !reload) begin
        getter   <= 1'b0;
        led      <= 4'b0000;
        alarm    <= 1'b0;
        win_open <= 1'b0;
        graded   <= 1'b0;
        sec_cnt  <= '0;
        tone_cnt <= '0;
        tick_cnt <= '0;
        if (!beginNew) begin
          for (int i = 0; i < 4; i++) score[i] <= 7'd0;
        end
      end else if (!getter) begin
        sec_cnt <= '0;
        if (claim) begin
          getter   <= 1'b1;
          led      <= ans;
          win_open <= 1'b1;
          alarm    <= 1'b1;
          tone_cnt <= '0;
          tick_cnt <= '0;
        end
      end else begin
        sec_cnt <= tick ? '0 : sec_cnt + SW'(1);
        if (win_open) begin
          if (tick && tick_cnt == AW'(ALARM_SEC - 1)) begin
            win_open <= 1'b0;
            alarm    <= 1'b0;
          end else begin
            if (tick) tick_cnt <= tick_cnt + AW'(1);
            if (tone_cnt == TW'(TONE_DIV - 1)) begin
              tone_cnt <= '0;
              alarm    <= ~alarm;
            end else begin
              tone_cnt <= tone_cnt + TW'(1);
            end
          end
        end
        // No takes precedence when both edges land together.
        if (!graded && (yes_e || no_e)) begin
          graded         <= 1'b1;
          score[win_idx] <= no_e ? sc_sub : sc_add;
        end
      end
    end
  end

  logic [CW-1:0] scan_cnt;
  logic [2:0]    slot;
  logic [2:0]    nslot;
  logic          slot_end;
  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic          held;
  logic          seen;
  logic          r_any;
  logic [1:0]    r_idx;
  logic [3:0]    code;

  assign slot_end = (scan_cnt == CW'(SCAN_DIV - 1));
  assign nslot    = slot_end ? slot + 3'd1 : slot;
  assign r_any    = (row_s2 != 4'b1111);
  assign code     = {r_idx, slot[1:0]};

  always_comb begin
    r_idx = 2'd0;
    priority case (1'b1)
      !row_s2[0]: r_idx = 2'd0;
      !row_s2[1]: r_idx = 2'd1;
      !row_s2[2]: r_idx = 2'd2;
      !row_s2[3]: r_idx = 2'd3;
      default:    r_idx = 2'd0;
    endcase
  end

  logic [1:0] pl;
  logic [6:0] sv;
  logic [3:0] dv;
  logic [6:0] pat;
  logic [7:0] seg_next;

  always_comb begin
    pl = 2'd3 - nslot[2:1];
    sv = score[pl];
    if (nslot[0]) dv = 4'(sv / 7'd10);
    else          dv = 4'(sv % 7'd10);
    case (dv)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    if (!en[pl] || (nslot[0] && dv == 4'd0)) seg_next = 8'hFF;
    else                                     seg_next = {1'b1, ~pat};
  end

  // Column, digit and segments all follow nslot so they switch together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      slot     <= 3'd0;
      col      <= 4'b1110;
      DIG      <= 8'b1111_1110;
      seg_out  <= 8'hFF;
      row_s1   <= 4'b1111;
      row_s2   <= 4'b1111;
      held     <= 1'b0;
      seen     <= 1'b0;
      pts      <= 4'd1;
    end else begin
      row_s1   <= row;
      row_s2   <= row_s1;
      scan_cnt <= slot_end ? '0 : scan_cnt + CW'(1);
      slot     <= nslot;
      col      <= ~(4'b0001 << nslot[1:0]);
      DIG      <= ~(8'b0000_0001 << nslot);
      seg_out  <= seg_next;
      // Rows sampled at slot end; a key only counts again after a
      // full column sweep with nothing pressed.
      if (slot_end) begin
        if (r_any && !held) begin
          held <= 1'b1;
          if (code >= 4'd1 && code <= 4'd9) pts <= code;
        end
        if (slot[1:0] == 2'd3) begin
          seen <= 1'b0;
          if (!r_any && !seen) held <= 1'b0;
        end else if (r_any) begin
          seen <= 1'b1;
        end
      end
      if (!beginNew) pts <= 4'd1;
    end
  end

endmodule

// File: tb/tb_quiz_buzzer_core.sv
// tb_quiz_buzzer_core: table vectors, directed corner sequences and
// randomized traffic against a cycle-count reference model.
module tb_quiz_buzzer_core;

  localparam int SEC_DIV   = 20;
  localparam int TONE_DIV  = 2;
  localparam int SCAN_DIV  = 4;
  localparam int ALARM_SEC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       reload;
  logic       beginNew;
  logic [3:0] Answer;
  logic       Yes;
  logic       No;
  logic       select1;
  logic       select2;
  logic [3:0] row;
  logic [3:0] col;
  logic [7:0] DIG;
  logic [7:0] seg_out;
  logic       getter;
  logic [3:0] led;
  logic       alarm;

  logic       key_on;
  logic [3:0] key_code;

  int n_vec = 0;
  int n_bad = 0;

  logic       m_getter;
  logic       m_graded;
  logic       yp;
  logic       np;
  logic [3:0] m_led;
  int         m_k;
  int         m_p;
  int         m_score [4];

  always #5 clk = ~clk;

  // Keypad: the pressed key pulls its row low while its column is driven.
  assign row = (key_on && col[key_code[1:0]] == 1'b0) ?
               ~(4'b0001 << key_code[3:2]) : 4'b1111;

  quiz_buzzer_core #(
    .SEC_DIV(SEC_DIV),
    .TONE_DIV(TONE_DIV),
    .SCAN_DIV(SCAN_DIV),
    .ALARM_SEC(ALARM_SEC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .reload(reload),
    .beginNew(beginNew),
    .Answer(Answer),
    .Yes(Yes),
    .No(No),
    .select1(select1),
    .select2(select2),
    .row(row),
    .col(col),
    .DIG(DIG),
    .seg_out(seg_out),
    .getter(getter),
    .led(led),
    .alarm(alarm)
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] a1;
    logic       g1;
    logic [3:0] l1;
    logic [3:0] a2;
    logic       g2;
    logic [3:0] l2;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] en_mask();
    int n;
    case ({select2, select1})
      2'b01:   n = 2;
      2'b10:   n = 3;
      default: n = 4;
    endcase
    return 4'((1 << n) - 1);
  endfunction

  function automatic logic [6:0] seg7(input int v);
    logic [6:0] t [10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[v];
  endfunction

  function automatic logic [7:0] exp_digit(input int d);
    int p;
    int v;
    logic [3:0] m;
    p = 3 - d / 2;
    m = en_mask();
    if (!m[p]) return 8'hFF;
    if (d % 2 == 1) begin
      v = m_score[p] / 10;
      if (v == 0) return 8'hFF;
    end else begin
      v = m_score[p] % 10;
    end
    return {1'b1, ~seg7(v)};
  endfunction

  function automatic logic exp_alarm();
    return (m_k >= 0) && (m_k < ALARM_SEC * SEC_DIV) &&
           ((m_k / TONE_DIV) % 2 == 0);
  endfunction

  task automatic model_reset();
    m_getter = 1'b0;
    m_graded = 1'b0;
    m_led    = 4'b0000;
    m_k      = -1;
    m_p      = 1;
    yp       = 1'b0;
    np       = 1'b0;
    for (int i = 0; i < 4; i++) m_score[i] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] a;
    logic ye;
    logic ne;
    int w;
    ye = Yes && !yp;
    ne = No && !np;
    if (!beginNew || !reload) begin
      m_getter = 1'b0;
      m_led    = 4'b0000;
      m_k      = -1;
      m_graded = 1'b0;
      if (!beginNew) begin
        for (int i = 0; i < 4; i++) m_score[i] = 0;
        m_p = 1;
      end
    end else if (!m_getter) begin
      a = Answer & en_mask();
      if ($countones(a) == 1) begin
        m_getter = 1'b1;
        m_led    = a;
        m_k      = 0;
      end
    end else begin
      m_k++;
      if (!m_graded && (ye || ne)) begin
        m_graded = 1'b1;
        w = 0;
        for (int i = 0; i < 4; i++) if (m_led[i]) w = i;
        if (ne) m_score[w] = (m_score[w] > m_p) ? m_score[w] - m_p : 0;
        else    m_score[w] = (m_score[w] + m_p > 99) ? 99 : m_score[w] + m_p;
      end
    end
    yp = Yes;
    np = No;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("getter", 32'(getter), 32'(m_getter));
    chk("led", 32'(led), 32'(m_led));
    chk("alarm", 32'(alarm), 32'(exp_alarm()));
  endtask

  task automatic do_reload();
    reload = 1'b0;
    tick();
    reload = 1'b1;
  endtask

  task automatic claim(input logic [3:0] a);
    Answer = a;
    tick();
    Answer = 4'b0000;
  endtask

  task automatic grade(input logic y, input logic n);
    Yes = y;
    No  = n;
    tick();
    Yes = 1'b0;
    No  = 1'b0;
    tick();
  endtask

  task automatic press_key(input logic [3:0] k);
    key_code = k;
    key_on   = 1'b1;
    repeat (40) tick();
    key_on = 1'b0;
    repeat (40) tick();
    if (k >= 4'd1 && k <= 4'd9) m_p = int'(k);
  endtask

  task automatic check_display();
    logic [7:0] cap [8];
    logic [7:0] oc;
    logic [3:0] cc;
    logic col_ok;
    int dg;
    for (int i = 0; i < 8; i++) cap[i] = 8'h00;
    col_ok = 1'b1;
    repeat (8 * SCAN_DIV + 2) begin
      tick();
      dg = -1;
      for (int i = 0; i < 8; i++) begin
        oc = 8'b1 << i;
        if (DIG == ~oc) dg = i;
      end
      if (dg >= 0) begin
        cap[dg] = seg_out;
        cc = 4'b1 << (dg % 4);
        if (col !== ~cc) col_ok = 1'b0;
      end else begin
        col_ok = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++) chk($sformatf("digit%0d", i),
                                    32'(cap[i]), 32'(exp_digit(i)));
    chk("col_scan", 32'(col_ok), 32'(1'b1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'b00, 4'b0100, 1'b1, 4'b0100, 4'b0001, 1'b1, 4'b0100};
    tbl[1] = '{2'b01, 4'b0100, 1'b0, 4'b0000, 4'b0011, 1'b0, 4'b0000};
    tbl[2] = '{2'b01, 4'b0011, 1'b0, 4'b0000, 4'b0010, 1'b1, 4'b0010};
    tbl[3] = '{2'b10, 4'b1000, 1'b0, 4'b0000, 4'b0100, 1'b1, 4'b0100};
    tbl[4] = '{2'b11, 4'b1000, 1'b1, 4'b1000, 4'b0110, 1'b1, 4'b1000};
    tbl[5] = '{2'b00, 4'b0000, 1'b0, 4'b0000, 4'b1100, 1'b0, 4'b0000};
    tbl[6] = '{2'b10, 4'b0101, 1'b0, 4'b0000, 4'b0001, 1'b1, 4'b0001};
    tbl[7] = '{2'b01, 4'b1100, 1'b0, 4'b0000, 4'b0001, 1'b1, 4'b0001};

    rst = 1'b0; reload = 1'b1; beginNew = 1'b1; Answer = 4'b0000;
    Yes = 1'b0; No = 1'b0; select1 = 1'b0; select2 = 1'b0;
    key_on = 1'b0; key_code = 4'd0;
    model_reset();
    #12;
    chk("rst_getter", 32'(getter), 32'(1'b0));
    chk("rst_led", 32'(led), 32'(4'b0000));
    chk("rst_alarm", 32'(alarm), 32'(1'b0));
    chk("rst_col", 32'(col), 32'(4'b1110));
    chk("rst_dig", 32'(DIG), 32'(8'b1111_1110));
    chk("rst_seg", 32'(seg_out), 32'(8'hFF));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_reload();
      {select2, select1} = tbl[i].sel;
      Answer = tbl[i].a1;
      tick();
      chk($sformatf("tbl%0d_g1", i), 32'(getter), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d_l1", i), 32'(led), 32'(tbl[i].l1));
      Answer = tbl[i].a2;
      tick();
      chk($sformatf("tbl%0d_g2", i), 32'(getter), 32'(tbl[i].g2));
      chk($sformatf("tbl%0d_l2", i), 32'(led), 32'(tbl[i].l2));
      Answer = 4'b0000;
    end

    // Full alarm window and its silent tail.
    {select2, select1} = 2'b00;
    do_reload();
    claim(4'b0100);
    repeat (200) tick();

    // Only the first Yes edge of a round grades; P survives reload.
    do_reload();
    claim(4'b0010);
    repeat (3) grade(1'b1, 1'b0);
    check_display();
    do_reload();
    claim(4'b0010);
    press_key(4'd5);
    grade(1'b1, 1'b0);
    check_display();

    // Sliding from one key to another without release is not a new press.
    do_reload();
    claim(4'b1000);
    key_code = 4'd3;
    key_on   = 1'b1;
    repeat (40) tick();
    key_code = 4'd7;
    repeat (40) tick();
    key_on = 1'b0;
    repeat (40) tick();
    m_p = 3;
    grade(1'b1, 1'b0);
    press_key(4'd0);
    press_key(4'd12);
    do_reload();
    claim(4'b1000);
    grade(1'b1, 1'b0);
    check_display();

    // Saturation at both ends, and No beating a simultaneous Yes.
    do_reload();
    claim(4'b0001);
    grade(1'b0, 1'b1);
    press_key(4'd9);
    repeat (10) begin
      do_reload();
      claim(4'b0100);
      grade(1'b1, 1'b0);
    end
    press_key(4'd8);
    do_reload();
    claim(4'b0100);
    grade(1'b1, 1'b0);
    press_key(4'd5);
    do_reload();
    claim(4'b0100);
    grade(1'b1, 1'b0);
    check_display();
    do_reload();
    claim(4'b0100);
    grade(1'b1, 1'b1);
    check_display();

    // New game in the middle of a beep, two players enabled.
    {select2, select1} = 2'b01;
    do_reload();
    claim(4'b0001);
    repeat (5) tick();
    beginNew = 1'b0;
    tick();
    beginNew = 1'b1;
    repeat (3) tick();
    check_display();

    // Asynchronous reset while the beeper is high.
    {select2, select1} = 2'b00;
    do_reload();
    claim(4'b1000);
    #2 rst = 1'b0;
    #1;
    chk("arst_alarm", 32'(alarm), 32'(1'b0));
    chk("arst_getter", 32'(getter), 32'(1'b0));
    chk("arst_led", 32'(led), 32'(4'b0000));
    chk("arst_seg", 32'(seg_out), 32'(8'hFF));
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    for (int c = 0; c < 1500; c++) begin
      int r;
      r = int'($urandom_range(0, 999));
      reload   = !(r < 8);
      beginNew = !(r >= 8 && r < 11);
      Answer = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if ($urandom_range(0, 5) == 0) Yes = ~Yes;
      if ($urandom_range(0, 7) == 0) No = ~No;
      if ($urandom_range(0, 99) == 0) {select2, select1} = 2'($urandom_range(0, 3));
      tick();
      if ($urandom_range(0, 149) == 0) begin
        reload = 1'b1; beginNew = 1'b1; Answer = 4'b0000;
        press_key(4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 199) == 0) begin
        reload = 1'b1; beginNew = 1'b1; Answer = 4'b0000;
        check_display();
      end
    end
    reload = 1'b1; beginNew = 1'b1; Answer = 4'b0000;
    check_display();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
